// File: rtl/rom_reader_pkg.sv
// Shared state encodings and helpers for the ROM read sequencer.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/rom_reader.sv
// Z80 read sequencer for a synchronous ROM with one-cycle registered output,
// with a one-entry last-address buffer that short-circuits repeated reads.
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter  int KB = 8,
  localparam int AW = $clog2(KB * 1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic          invalidate,
  output logic          ack,
  output logic [7:0]    data_out,
  output logic          wait_n,
  output logic          rom_ce,
  output logic [AW-1:0] rom_address,
  input  logic [7:0]    rom_q
);

  state_e        state_q, state_d;
  logic          ack_q, ack_d;
  logic          rom_ce_q, rom_ce_d;
  logic [AW-1:0] rom_address_q, rom_address_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          buf_valid_q, buf_valid_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;

  // A buffer hit is suppressed when invalidate arrives on the same edge.
  logic hit;
  assign hit = buf_valid_q && !invalidate && (addr == buf_addr_q);

  // NOTE: every _d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    ack_d         = ack_q;
    rom_ce_d      = 1'b0;
    rom_address_d = rom_address_q;
    data_out_d    = data_out_q;
    buf_valid_d   = buf_valid_q;
    buf_addr_d    = buf_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (req && hit) begin
          ack_d   = 1'b1;
          state_d = S_DONE;
        end else if (req) begin
          rom_address_d = addr;
          rom_ce_d      = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        // The fill always completes, even if the CPU abandoned the request.
        data_out_d  = rom_q;
        buf_addr_d  = rom_address_q;
        buf_valid_d = 1'b1;
        if (req && (addr == rom_address_q)) begin
          ack_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (!req || (addr != buf_addr_q)) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (invalidate) buf_valid_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ack_q         <= 1'b0;
      rom_ce_q      <= 1'b0;
      rom_address_q <= '0;
      data_out_q    <= 8'h00;
      buf_valid_q   <= 1'b0;
      buf_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      rom_ce_q      <= rom_ce_d;
      rom_address_q <= rom_address_d;
      data_out_q    <= data_out_d;
      buf_valid_q   <= buf_valid_d;
      buf_addr_q    <= buf_addr_d;
    end
  end

  assign ack         = ack_q;
  assign data_out    = data_out_q;
  assign rom_ce      = rom_ce_q;
  assign rom_address = rom_address_q;
  assign wait_n      = ~(req & ~ack_q);

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with a one-cycle registered ROM model.
module tb_rom_reader;

  localparam int KB = 8;
  localparam int AW = 13;

  logic          clock = 1'b0;
  logic          reset;
  logic          req;
  logic [AW-1:0] addr;
  logic          invalidate;
  logic          ack;
  logic [7:0]    data_out;
  logic          wait_n;
  logic          rom_ce;
  logic [AW-1:0] rom_address;
  logic [7:0]    rom_q = 8'h00;

  logic [7:0] mem [0:(KB*1024)-1];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int ce_count = 0;

  rom_reader #(.KB(KB)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .addr        (addr),
    .invalidate  (invalidate),
    .ack         (ack),
    .data_out    (data_out),
    .wait_n      (wait_n),
    .rom_ce      (rom_ce),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rom_ce === 1'b1) begin
      rom_q <= mem[rom_address];
      ce_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < KB * 1024; i++) mem[i] = 8'h00;
    mem[13'h0123] = 8'h5A;
    mem[13'h1FFF] = 8'hC3;

    // 1: reset
    reset = 1'b1; req = 1'b0; addr = '0; invalidate = 1'b0;
    repeat (3) edge1();
    check("rst_ack", ack, 0);
    check("rst_ce", rom_ce, 0);
    check("rst_data", data_out, 8'h00);
    check("rst_wait_n", wait_n, 1);
    reset = 1'b0;
    edge1();
    req = 1'b1; addr = 13'h0123;
    edge1();
    check("pre_async_ce", rom_ce, 1);
    #2 reset = 1'b1;
    #1;
    check("async_ce", rom_ce, 0);
    check("async_addr", rom_address, 0);
    req = 1'b0;
    edge1();
    reset = 1'b0;
    edge1();

    // 2: miss on 0x0123
    req = 1'b1; addr = 13'h0123; ce_count = 0;
    #1;
    check("miss_wait_n_low", wait_n, 0);
    edge1();
    check("miss_ce_hi", rom_ce, 1);
    check("miss_rom_addr", rom_address, 13'h0123);
    check("miss_ack_e1", ack, 0);
    edge1();
    check("miss_ce_lo", rom_ce, 0);
    check("miss_ack_e2", ack, 0);
    edge1();
    check("miss_ack_e3", ack, 1);
    check("miss_data", data_out, 8'h5A);
    check("miss_wait_n_hi", wait_n, 1);
    check("miss_ce_count", ce_count, 1);

    // 3: hit on 0x0123
    req = 1'b0;
    edge1();
    check("hit_ack_drop", ack, 0);
    req = 1'b1; ce_count = 0;
    #1;
    check("hit_wait_n_low", wait_n, 0);
    edge1();
    check("hit_ack", ack, 1);
    check("hit_data", data_out, 8'h5A);
    check("hit_ce_count", ce_count, 0);

    // 4: address change while in DONE
    addr = 13'h1FFF; ce_count = 0;
    edge1();
    check("chg_ack_fall", ack, 0);
    check("chg_wait_n", wait_n, 0);
    edge1();
    check("chg_ce_hi", rom_ce, 1);
    check("chg_rom_addr", rom_address, 13'h1FFF);
    edge1();
    edge1();
    check("chg_ack", ack, 1);
    check("chg_data", data_out, 8'hC3);
    check("chg_ce_count", ce_count, 1);

    // 5: invalidate in DONE keeps ack; abort fills buffer; invalidate with req forces miss
    invalidate = 1'b1;
    edge1();
    invalidate = 1'b0;
    check("inval_ack_kept", ack, 1);
    req = 1'b0;
    edge1();
    req = 1'b1; ce_count = 0;
    edge1();
    check("abort_ce_hi", rom_ce, 1);
    req = 1'b0;
    edge1();
    edge1();
    check("abort_no_ack", ack, 0);
    check("abort_data", data_out, 8'hC3);
    req = 1'b1;
    edge1();
    check("abort_buf_hit", ack, 1);
    check("abort_ce_count", ce_count, 1);
    req = 1'b0;
    edge1();
    req = 1'b1; invalidate = 1'b1; ce_count = 0;
    edge1();
    invalidate = 1'b0;
    check("inval_req_miss", rom_ce, 1);
    check("inval_req_ack", ack, 0);
    edge1();
    invalidate = 1'b1;
    edge1();
    invalidate = 1'b0;
    check("inval_cap_ack", ack, 1);
    check("inval_cap_data", data_out, 8'hC3);
    req = 1'b0;
    edge1();
    req = 1'b1;
    edge1();
    check("inval_cap_miss", rom_ce, 1);
    check("inval_cap_no_hit", ack, 0);
    edge1();
    edge1();
    check("inval_cap_ack2", ack, 1);

    // 6: reset while in CAPTURE
    req = 1'b0;
    edge1();
    req = 1'b1; addr = 13'h0123;
    edge1();
    edge1();
    #2 reset = 1'b1;
    #1;
    check("rst_cap_ack", ack, 0);
    check("rst_cap_ce", rom_ce, 0);
    check("rst_cap_data", data_out, 8'h00);
    req = 1'b0;
    edge1();
    reset = 1'b0;
    edge1();
    req = 1'b1; ce_count = 0;
    #1;
    check("post_rst_wait_n", wait_n, 0);
    edge1();
    check("post_rst_ce", rom_ce, 1);
    edge1();
    check("post_rst_ack_e2", ack, 0);
    edge1();
    check("post_rst_ack", ack, 1);
    check("post_rst_data", data_out, 8'h5A);
    check("post_rst_ce_count", ce_count, 1);

    req = 1'b0;
    edge1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
